// File: rtl/if_is_fifo_if.sv
// IF->FIFO->IS instruction stream bundle: enqueue side driven by fetch,
// dequeue side consumed by issue.
interface if_is_fifo_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_ir;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_ir;

  modport master (
    output in_valid, in_pc, in_ir, out_ready,
    input  in_ready, out_valid, out_pc, out_ir
  );

  modport slave (
    input  in_valid, in_pc, in_ir, out_ready,
    output in_ready, out_valid, out_pc, out_ir
  );
endinterface

// File: rtl/if_is_fifo.sv
// Fetch-to-issue instruction FIFO: circular buffer of {pc, ir} with flush,
// no fall-through, and a bubble instruction presented while empty.
module if_is_fifo #(
  parameter int unsigned     XLEN   = 32,
  parameter int unsigned     DEPTH  = 4,
  parameter logic [XLEN-1:0] BUBBLE = XLEN'(32'h00000013)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  if_is_fifo_if.slave                  bus,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] ir_mem [DEPTH];
  logic            room;
  logic            avail;
  logic            push;
  logic            pop;

  always_comb begin
    room  = (cnt != CW'(DEPTH));
    avail = (cnt != '0);
    push  = bus.in_valid && room && !flush;
    pop   = avail && bus.out_ready && !flush;
  end

  assign bus.in_ready  = room;
  assign bus.out_valid = avail;
  assign bus.out_pc    = avail ? pc_mem[rp] : '0;
  assign bus.out_ir    = avail ? ir_mem[rp] : BUBBLE;
  assign count         = cnt;

  // DEPTH is a power of two, so pointer wrap is plain modular increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is never cleared; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wp] <= bus.in_pc;
      ir_mem[wp] <= bus.in_ir;
    end
  end

endmodule

// File: tb/tb_if_is_fifo.sv
// Self-checking bench for if_is_fifo at DEPTH 2/4/8 against a queue-based model.
module tb_if_is_fifo;

  localparam logic [31:0] BUB = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_ir = '0;
  logic [1:0]  cnt2;
  logic [2:0]  cnt4;
  logic [3:0]  cnt8;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  if_is_fifo_if #(.XLEN(32)) b2 ();
  if_is_fifo_if #(.XLEN(32)) b4 ();
  if_is_fifo_if #(.XLEN(32)) b8 ();

  assign b2.in_valid = in_valid;  assign b2.in_pc = in_pc;
  assign b2.in_ir = in_ir;        assign b2.out_ready = out_ready;
  assign b4.in_valid = in_valid;  assign b4.in_pc = in_pc;
  assign b4.in_ir = in_ir;        assign b4.out_ready = out_ready;
  assign b8.in_valid = in_valid;  assign b8.in_pc = in_pc;
  assign b8.in_ir = in_ir;        assign b8.out_ready = out_ready;

  if_is_fifo #(.XLEN(32), .DEPTH(2)) u2 (.clk(clk), .rst(rst), .flush(flush), .bus(b2), .count(cnt2));
  if_is_fifo #(.XLEN(32), .DEPTH(4)) u4 (.clk(clk), .rst(rst), .flush(flush), .bus(b4), .count(cnt4));
  if_is_fifo #(.XLEN(32), .DEPTH(8)) u8 (.clk(clk), .rst(rst), .flush(flush), .bus(b8), .count(cnt8));

  // Reference model: one queue of {pc, ir} per instance.
  typedef logic [63:0] ent_t;
  ent_t        q [3][$];
  int unsigned dep [3] = '{2, 4, 8};

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      if (rst || flush) q[k].delete();
      else begin
        int unsigned sz = q[k].size();
        logic do_pop  = (sz != 0) && out_ready;
        logic do_push = in_valid && (sz != dep[k]);
        if (do_pop)  void'(q[k].pop_front());
        if (do_push) q[k].push_back({in_pc, in_ir});
      end
    end
  endtask

  task automatic check_dut(string tag, int k, logic ir, logic ov,
                           logic [31:0] opc, logic [31:0] oir, logic [31:0] c);
    int unsigned sz = q[k].size();
    ent_t head = (sz != 0) ? q[k][0] : '0;
    cmp({tag, ".in_ready"},  32'(ir),  32'(sz != dep[k]));
    cmp({tag, ".out_valid"}, 32'(ov),  32'(sz != 0));
    cmp({tag, ".out_pc"},    opc,      (sz != 0) ? head[63:32] : 32'h0);
    cmp({tag, ".out_ir"},    oir,      (sz != 0) ? head[31:0]  : BUB);
    cmp({tag, ".count"},     c,        32'(sz));
  endtask

  task automatic check_model();
    check_dut("d2", 0, b2.in_ready, b2.out_valid, b2.out_pc, b2.out_ir, 32'(cnt2));
    check_dut("d4", 1, b4.in_ready, b4.out_valid, b4.out_pc, b4.out_ir, 32'(cnt4));
    check_dut("d8", 2, b8.in_ready, b8.out_valid, b8.out_pc, b8.out_ir, 32'(cnt8));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  task automatic drive(logic f, logic v, logic r, logic [31:0] pc);
    flush = f; in_valid = v; out_ready = r; in_pc = pc; in_ir = ~pc;
  endtask

  typedef struct {
    logic        fl, v, rdy;
    logic [31:0] pc;
    int unsigned cnt;
    logic        ir, ov;
    logic [31:0] opc;
  } vec_t;
  vec_t tbl [20];

  initial begin
    tbl = '{
      '{1'b0, 1'b1, 1'b0, 32'h00, 1, 1'b1, 1'b1, 32'h00},
      '{1'b0, 1'b1, 1'b0, 32'h04, 2, 1'b1, 1'b1, 32'h00},
      '{1'b0, 1'b1, 1'b0, 32'h08, 3, 1'b1, 1'b1, 32'h00},
      '{1'b0, 1'b1, 1'b0, 32'h0C, 4, 1'b0, 1'b1, 32'h00},
      '{1'b0, 1'b1, 1'b0, 32'h10, 4, 1'b0, 1'b1, 32'h00},
      '{1'b0, 1'b0, 1'b1, 32'h00, 3, 1'b1, 1'b1, 32'h04},
      '{1'b0, 1'b0, 1'b1, 32'h00, 2, 1'b1, 1'b1, 32'h08},
      '{1'b0, 1'b0, 1'b1, 32'h00, 1, 1'b1, 1'b1, 32'h0C},
      '{1'b0, 1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b0, 32'h00},
      '{1'b0, 1'b1, 1'b0, 32'h20, 1, 1'b1, 1'b1, 32'h20},
      '{1'b0, 1'b1, 1'b0, 32'h24, 2, 1'b1, 1'b1, 32'h20},
      '{1'b0, 1'b1, 1'b1, 32'h28, 2, 1'b1, 1'b1, 32'h24},
      '{1'b0, 1'b1, 1'b1, 32'h2C, 2, 1'b1, 1'b1, 32'h28},
      '{1'b0, 1'b0, 1'b1, 32'h00, 1, 1'b1, 1'b1, 32'h2C},
      '{1'b0, 1'b1, 1'b0, 32'h30, 2, 1'b1, 1'b1, 32'h2C},
      '{1'b0, 1'b1, 1'b0, 32'h34, 3, 1'b1, 1'b1, 32'h2C},
      '{1'b1, 1'b1, 1'b1, 32'h38, 0, 1'b1, 1'b0, 32'h00},
      '{1'b0, 1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b0, 32'h00},
      '{1'b0, 1'b1, 1'b1, 32'h40, 1, 1'b1, 1'b1, 32'h40},
      '{1'b0, 1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b0, 32'h00}
    };

    // Reset state, asserted from time zero.
    #1;
    check_model();
    cycle();
    cycle();
    rst = 1'b0;

    // Table: fill/drain, blocked 5th push, simultaneous push/pop, flush.
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].fl, tbl[i].v, tbl[i].rdy, tbl[i].pc);
      cycle();
      cmp($sformatf("tbl%0d.count", i),     32'(cnt4),         32'(tbl[i].cnt));
      cmp($sformatf("tbl%0d.in_ready", i),  32'(b4.in_ready),  32'(tbl[i].ir));
      cmp($sformatf("tbl%0d.out_valid", i), 32'(b4.out_valid), 32'(tbl[i].ov));
      cmp($sformatf("tbl%0d.out_pc", i),    b4.out_pc,         tbl[i].opc);
      cmp($sformatf("tbl%0d.out_ir", i),    b4.out_ir,         tbl[i].ov ? ~tbl[i].opc : BUB);
    end

    // Steady-state wrap: one entry primed, then 10 push+pop cycles.
    drive(1'b0, 1'b1, 1'b0, 32'h100);
    cycle();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h100 + 32'(4 * i));
      cmp($sformatf("wrap%0d.head", i), b4.out_pc, 32'h100 + 32'(4 * (i - 1)));
      cycle();
      cmp($sformatf("wrap%0d.count", i), 32'(cnt4), 32'd1);
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    cycle();

    // Asynchronous reset with 3 entries buffered, checked before any edge.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h200 + 32'(4 * i));
      cycle();
    end
    cmp("pre_rst.count", 32'(cnt4), 32'd3);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) q[k].delete();
    cmp("rst.count",     32'(cnt4),         32'd0);
    cmp("rst.out_valid", 32'(b4.out_valid), 32'd0);
    cmp("rst.out_ir",    b4.out_ir,         BUB);
    cmp("rst.out_pc",    b4.out_pc,         32'h0);
    cmp("rst.in_ready",  32'(b4.in_ready),  32'd1);
    check_model();
    cycle();
    rst = 1'b0;

    // Depth sweep: fill with out_ready low; each instance saturates at DEPTH.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h300 + 32'(4 * i));
      cycle();
    end
    cmp("sweep.d2.count",    32'(cnt2),        32'd2);
    cmp("sweep.d2.in_ready", 32'(b2.in_ready), 32'd0);
    cmp("sweep.d8.count",    32'(cnt8),        32'd8);
    cmp("sweep.d8.in_ready", 32'(b8.in_ready), 32'd0);
    cmp("sweep.d8.head",     b8.out_pc,        32'h300);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h0);
      cycle();
    end

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 500; i++) begin
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 2) != 0;
      in_pc     = 32'h1000 + 32'(4 * i);
      in_ir     = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_is_fifo.md
IF_IS_FIFO -- requirements
Module: if_is_fifo

Interface
REQ-001 Parameters SHALL be:
- XLEN, default 32, instruction and PC width.
- DEPTH, default 4, number of entries; power of two, >=2.
- BUBBLE, default 32'h00000013, instruction presented when empty.
REQ-002 Ports SHALL be:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  control-hazard flush, discards all entries.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  FIFO can accept an instruction.
- in_pc  in  XLEN  PC of the fetched instruction.
- in_ir  in  XLEN  fetched instruction.
- out_valid  out  1  head entry valid for IS.
- out_ready  in  1  IS consumes the head entry.
- out_pc  out  XLEN  PC of the head entry.
- out_ir  out  XLEN  instruction of the head entry.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
REQ-003 Reset SHALL be rst, asynchronous, active-high; clock SHALL be clk.

Function
REQ-004 Storage SHALL be a circular buffer of DEPTH {pc, ir} entries with write pointer wp, read pointer rp and occupancy counter cnt.
REQ-005 Pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0.
REQ-006 in_ready SHALL be combinational: (cnt != DEPTH), independent of flush and out_ready.
- No same-cycle pop-makes-room bypass when full.
REQ-007 A push SHALL occur on a rising edge when in_valid && in_ready && !flush.
- Push writes {in_pc, in_ir} at wp and increments wp.
REQ-008 A pop SHALL occur on a rising edge when out_valid && out_ready && !flush.
- Pop increments rp.
REQ-009 cnt SHALL update per cycle as follows:
- Push only: +1.
- Pop only: -1.
- Push and pop together: unchanged; both pointers advance.
REQ-010 out_valid SHALL be (cnt != 0); count SHALL equal cnt.
REQ-011 When cnt != 0, out_pc and out_ir SHALL be the entry at rp, combinationally.
REQ-012 When cnt == 0, out_ir SHALL be BUBBLE and out_pc SHALL be 0.
- No fall-through: an entry pushed in cycle N is first visible at out_* in cycle N+1 (latency 1).
REQ-013 Flush SHALL take precedence over push and pop. On a rising edge with flush=1:
- wp, rp and cnt are set to 0.
- Any concurrent push or pop is discarded.
- From the next cycle: out_valid=0 and out_ir=BUBBLE.
REQ-014 Storage contents SHALL NOT be cleared by flush or reset; only pointers and counter are cleared.
REQ-015 Pop with cnt==0 and push with cnt==DEPTH SHALL be impossible by construction; state SHALL remain unchanged.
REQ-016 in_valid held while in_ready=0 SHALL have no effect; IF holds its data until accepted.

Reset
REQ-017 While rst=1, the FIFO SHALL hold:
- wp=0, rp=0, cnt=0.
- Outputs: in_ready=1, out_valid=0, count=0, out_ir=BUBBLE, out_pc=0.
REQ-018 Reset asserted mid-operation SHALL take effect immediately, without a clock edge.
- All buffered entries are discarded.
- Normal operation resumes on the first rising edge after rst deasserts.

Verification
REQ-019 Reset: assert rst with 3 entries buffered -> count=0, out_valid=0, out_ir=32'h00000013, out_pc=0, in_ready=1 with no clock edge.
REQ-020 Fill/drain: push PC 0x00,0x04,0x08,0x0C with out_ready=0 ->
- count=4, in_ready=0.
- A 5th push (PC 0x10) is not accepted.
- Then out_ready=1 yields out_pc 0x00,0x04,0x08,0x0C on consecutive cycles, then out_valid=0.
REQ-021 Simultaneous push/pop at cnt=2 -> count stays 2 and the FIFO order is preserved.
REQ-022 Wrap-around: push and pop 10 entries in steady state with DEPTH=4 -> PCs emerge in order across pointer wrap, no loss or duplication.
REQ-023 Flush with push and pop asserted at cnt=3 -> next cycle count=0, out_valid=0, out_ir=BUBBLE; the flushed-cycle push never appears.
REQ-024 Parameter sweep: DEPTH=2 and DEPTH=8 with XLEN=32 -> full asserts at exactly DEPTH entries; count width holds DEPTH without overflow.
